// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    // Number of high cycles in one output period of ratio n.
    function automatic int unsigned half(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered clk_out/tick derived from the next count.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] i_cur_div,
    input  logic             i_run,
    input  logic             i_restart,
    output logic             o_boundary_c,
    output logic             o_tick,
    output logic             o_clk_out
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_last;
    logic [DIV_W-1:0] w_high_from;

    assign w_last       = i_cur_div - DIV_W'(1);
    assign w_high_from  = i_cur_div - DIV_W'(half(32'(i_cur_div)));
    assign o_boundary_c = (r_cnt == w_last);

    // A ratio change only lands where the next count is 0, so the current ratio is safe here.
    assign w_cnt_nxt = (!i_run || i_restart || o_boundary_c) ? '0 : r_cnt + DIV_W'(1);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            o_tick    <= 1'b0;
            o_clk_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            o_tick    <= i_run && (w_cnt_nxt == w_last);
            o_clk_out <= i_run && (w_cnt_nxt >= w_high_from);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop sequencing, ratio handshake and glitch-free ratio switching for the divider.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [DIV_W-1:0] cur_div,
    output logic             tick,
    output logic             clk_out,
    output logic             locked
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DIV_W-1:0] r_pend_div;
    logic             w_core_boundary;
    logic             w_boundary;
    logic             w_running;
    logic             w_accept;
    logic             w_legal;
    logic             w_apply;
    logic             w_direct;

    assign w_running  = (r_state != IDLE);
    assign w_boundary = w_running && w_core_boundary;
    assign w_accept   = cfg_valid && cfg_ready;
    assign w_legal    = (cfg_div >= DIV_W'(DIV_MIN));
    // cfg_ready low means a ratio is waiting in r_pend_div.
    assign w_apply    = !cfg_ready && (!w_running || w_boundary);
    assign w_direct   = !w_running && (w_state_nxt == IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:           w_state_nxt = en ? RUN : IDLE;
            RUN, STOP_PEND: w_state_nxt = en ? RUN : (w_boundary ? IDLE : STOP_PEND);
            default:        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend_div <= '0;
            cur_div    <= DIV_W'(DIV_DEFAULT);
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            cfg_err <= w_accept && !w_legal;

            if (w_apply) begin
                cur_div   <= r_pend_div;
                cfg_ready <= 1'b1;
            end else if (w_accept && w_legal) begin
                if (w_direct) begin
                    cur_div <= cfg_div;
                end else begin
                    r_pend_div <= cfg_div;
                    cfg_ready  <= 1'b0;
                end
            end

            if ((w_state_nxt == IDLE) || (w_accept && w_legal)) begin
                locked <= 1'b0;
            end else if (w_boundary && cfg_ready) begin
                locked <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .i_cur_div    (cur_div),
        .i_run        (w_state_nxt != IDLE),
        .i_restart    (!w_running),
        .o_boundary_c (w_core_boundary),
        .o_tick       (tick),
        .o_clk_out    (clk_out)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed plus randomized bench for clk_div_ctrl against a cycle-level behavioural model.
module tb_clk_div_ctrl;

    localparam int unsigned DIV_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [DIV_W-1:0] cur_div;
    logic             tick;
    logic             clk_out;
    logic             locked;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0=idle, 1=run, 2=stopping; cnt is the position within the period.
    int m_mode, m_cnt, m_n, m_pdiv;
    bit m_ready, m_err, m_lock, e_clk, e_tick;

    clk_div_ctrl #(.DIV_W(DIV_W), .DIV_DEFAULT(5)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_div   (cur_div),
        .tick      (tick),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit last, acc, legal, ready_old;
        int nm, nc, nn;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_n = 5; m_pdiv = 0;
            m_ready = 1; m_err = 0; m_lock = 0; e_clk = 0; e_tick = 0;
            return;
        end
        last      = (m_mode != 0) && (m_cnt == m_n - 1);
        acc       = cfg_valid && m_ready;
        legal     = (int'(cfg_div) >= 2);
        ready_old = m_ready;
        if (m_mode == 0) nm = en ? 1 : 0;
        else             nm = en ? 1 : (last ? 0 : 2);
        nc    = (m_mode == 0 || nm == 0 || last) ? 0 : m_cnt + 1;
        m_err = acc && !legal;
        nn    = m_n;
        if (!m_ready && (m_mode == 0 || last)) begin
            nn      = m_pdiv;
            m_ready = 1;
        end else if (acc && legal) begin
            if (m_mode == 0 && nm == 0) begin
                nn = int'(cfg_div);
            end else begin
                m_pdiv  = int'(cfg_div);
                m_ready = 0;
            end
        end
        if (nm == 0 || (acc && legal)) m_lock = 0;
        else if (last && ready_old)    m_lock = 1;
        m_mode = nm;
        m_cnt  = nc;
        m_n    = nn;
        e_clk  = (nm != 0) && (nc >= nn - nn / 2);
        e_tick = (nm != 0) && (nc == nn - 1);
    endtask

    task automatic drive(input bit r, input bit e, input bit v, input int d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rst_n     = r;
            en        = e;
            cfg_valid = v && (i == 0);
            cfg_div   = DIV_W'(d);
            @(posedge clk_in);
            model_step();
            #1;
            check_eq("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            check_eq("cfg_err",   32'(cfg_err),   32'(m_err));
            check_eq("cur_div",   32'(cur_div),   32'(m_n));
            check_eq("tick",      32'(tick),      32'(e_tick));
            check_eq("clk_out",   32'(clk_out),   32'(e_clk));
            check_eq("locked",    32'(locked),    32'(m_lock));
        end
    endtask

    initial begin
        bit r_en;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

        drive(0, 0, 0, 0, 2);
        drive(1, 1, 0, 0, 12);
        drive(1, 0, 0, 0, 6);
        drive(1, 0, 1, 4, 1);
        drive(1, 1, 0, 0, 10);
        drive(1, 0, 0, 0, 6);
        drive(1, 0, 1, 5, 2);
        drive(1, 1, 0, 0, 2);
        drive(1, 1, 1, 8, 1);
        drive(1, 1, 0, 0, 24);
        drive(1, 1, 1, 0, 2);
        drive(1, 1, 1, 1, 2);
        drive(1, 0, 0, 0, 12);
        drive(1, 0, 1, 6, 1);
        drive(1, 1, 0, 0, 9);
        drive(1, 0, 0, 0, 9);
        drive(1, 1, 0, 0, 3);
        drive(1, 0, 0, 0, 4);
        drive(1, 1, 0, 0, 10);
        drive(1, 1, 1, 9, 4);
        drive(0, 1, 0, 0, 1);
        drive(1, 1, 1, 2, 1);
        drive(1, 1, 0, 0, 12);
        drive(1, 1, 1, 255, 1);
        drive(1, 1, 0, 0, 520);
        drive(1, 1, 1, 3, 1);
        drive(1, 1, 0, 0, 300);

        r_en = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 39) == 0) r_en = !r_en;
            drive(($urandom_range(0, 499) != 0), r_en,
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 9)),
                  1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
